rr_arbiter_8: RTL and testbench

RR_ARBITER_8 -- requirements
Module: rr_arbiter_8

---
 rtl/arb_pkg.sv | 13 +
 rtl/rr_pick_8x3.sv | 33 +++
 rtl/rr_arbiter_8.sv | 93 +++++++++
 tb/tb_rr_arbiter_8.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and constants for the 8-way round-robin arbiter.
package arb_pkg;

    localparam int unsigned N_REQ        = 8;
    localparam int unsigned IDX_W        = 3;
    localparam int unsigned MAX_HOLD_DEF = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_pick_8x3.sv
// Round-robin pick: rotate requests so the search begins at last+1, then
// priority-encode the lowest set bit and rotate the index back.
module rr_pick_8x3
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    logic [IDX_W-1:0]   start;
    logic [2*N_REQ-1:0] dbl;
    logic [N_REQ-1:0]   rot;
    logic [IDX_W-1:0]   offset;

    always_comb begin
        start  = last + 1'b1;
        dbl    = {req, req} >> start;
        rot    = dbl[N_REQ-1:0];
        offset = '0;
        found  = 1'b0;
        // Descending scan so the lowest set bit of the rotated vector wins.
        for (int unsigned i = N_REQ; i > 0; i--) begin
            if (rot[i-1]) begin
                offset = IDX_W'(i - 1);
                found  = 1'b1;
            end
        end
        idx = start + offset;
    end

endmodule

// File: rtl/rr_arbiter_8.sv
// 8-requester round-robin arbiter with registered one-hot grant, bounded
// hold time and a one-cycle timeout pulse when a grant is revoked.
module rr_arbiter_8
    import arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = MAX_HOLD_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             En,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid,
    output logic             timeout
);

    localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);

    arb_state_t       state, state_next;
    logic [7:0]       hold, hold_next;
    logic [IDX_W-1:0] last, last_next;
    logic [IDX_W-1:0] idx_next;
    logic [N_REQ-1:0] gnt_next;
    logic             valid_next;
    logic             timeout_next;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_found;

    rr_pick_8x3 u_pick (
        .req   (req),
        .last  (last),
        .idx   (pick_idx),
        .found (pick_found)
    );

    always_comb begin
        state_next   = state;
        hold_next    = hold;
        last_next    = last;
        gnt_next     = gnt;
        idx_next     = gnt_idx;
        valid_next   = gnt_valid;
        timeout_next = 1'b0;
        unique case (state)
            IDLE: begin
                if (En && pick_found) begin
                    state_next = GRANT;
                    last_next  = pick_idx;
                    idx_next   = pick_idx;
                    gnt_next   = N_REQ'(1) << pick_idx;
                    valid_next = 1'b1;
                    hold_next  = 8'd1;
                end
            end
            GRANT: begin
                // A dropped request releases normally even on the final hold cycle.
                if (!req[gnt_idx] || hold == HOLD_MAX) begin
                    state_next   = IDLE;
                    gnt_next     = '0;
                    idx_next     = '0;
                    valid_next   = 1'b0;
                    hold_next    = '0;
                    timeout_next = req[gnt_idx];
                end else begin
                    hold_next = hold + 8'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            hold      <= '0;
            last      <= '1;
            gnt       <= '0;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            state     <= state_next;
            hold      <= hold_next;
            last      <= last_next;
            gnt       <= gnt_next;
            gnt_idx   <= idx_next;
            gnt_valid <= valid_next;
            timeout   <= timeout_next;
        end
    end

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Bench for rr_arbiter_8: directed scenarios plus random traffic against a
// cycle-level behavioural model of the arbitration rules.
module tb_rr_arbiter_8;

    localparam int unsigned MAXH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       En;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: whether someone holds the bus, who, for how many cycles so far,
    // who was granted most recently, and whether a timeout just happened.
    bit m_busy;
    bit m_to;
    int m_idx;
    int m_held;
    int m_last;

    always #5 clk = ~clk;

    rr_arbiter_8 #(.MAX_HOLD(MAXH)) dut (
        .clk       (clk),
        .rst       (rst),
        .En        (En),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 0;
        m_to   = 0;
        m_idx  = 0;
        m_held = 0;
        m_last = 7;
    endtask

    task automatic model_step();
        int pick;
        m_to = 0;
        if (m_busy) begin
            if (!req[m_idx]) begin
                m_busy = 0;
            end else if (m_held == int'(MAXH)) begin
                m_busy = 0;
                m_to   = 1;
            end else begin
                m_held++;
            end
        end else if (En && req != 8'h00) begin
            pick = -1;
            for (int k = 1; k <= 8; k++) begin
                if (pick < 0 && req[(m_last + k) % 8]) pick = (m_last + k) % 8;
            end
            m_busy = 1;
            m_idx  = pick;
            m_last = pick;
            m_held = 1;
        end
    endtask

    task automatic check_model();
        logic [7:0] eg;
        eg = m_busy ? (8'd1 << m_idx) : 8'd0;
        check("gnt", 32'(gnt), 32'(eg));
        check("gnt_idx", 32'(gnt_idx), m_busy ? 32'(m_idx) : 32'd0);
        check("gnt_valid", 32'(gnt_valid), 32'(m_busy));
        check("timeout", 32'(timeout), 32'(m_to));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_model();
    endtask

    // Called at a falling edge: reset is asserted and released between edges.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        check_model();
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        En  = 1'b0;
        req = 8'h00;
        model_reset();
        @(negedge clk);
        do_reset();

        // Scenario 1: single requester 3
        req = 8'h08;
        En  = 1'b1;
        cycle();
        check("s1_gnt", 32'(gnt), 32'h08);
        check("s1_idx", 32'(gnt_idx), 32'd3);
        check("s1_valid", 32'(gnt_valid), 32'd1);
        req = 8'h00;
        cycle();
        cycle();

        // Scenario 2: all requesting, full rotation with timeouts
        do_reset();
        req = 8'hFF;
        En  = 1'b1;
        for (int g = 0; g < 9; g++) begin
            cycle();
            check("s2_order", 32'(gnt_idx), 32'(g % 8));
            check("s2_valid", 32'(gnt_valid), 32'd1);
            repeat (3) cycle();
            cycle();
            check("s2_timeout", 32'(timeout), 32'd1);
            check("s2_idle", 32'(gnt_valid), 32'd0);
        end
        req = 8'h00;
        cycle();
        cycle();

        // Scenario 3: drop at idx 6, next grant wraps to 0
        do_reset();
        req = 8'h40;
        cycle();
        check("s3_idx6", 32'(gnt_idx), 32'd6);
        req = 8'h41;
        cycle();
        cycle();
        check("s3_hold6", 32'(gnt_idx), 32'd6);
        req = 8'h01;
        cycle();
        check("s3_idle", 32'(gnt_valid), 32'd0);
        check("s3_no_to", 32'(timeout), 32'd0);
        cycle();
        check("s3_wrap0", 32'(gnt_idx), 32'd0);
        req = 8'h00;
        cycle();
        cycle();

        // Scenario 4: enable gating
        do_reset();
        En  = 1'b0;
        req = 8'h10;
        repeat (3) begin
            cycle();
            check("s4_blocked", 32'(gnt_valid), 32'd0);
        end
        En = 1'b1;
        cycle();
        check("s4_idx4", 32'(gnt_idx), 32'd4);
        En = 1'b0;
        repeat (3) cycle();
        check("s4_persist", 32'(gnt_valid), 32'd1);
        cycle();
        check("s4_timeout", 32'(timeout), 32'd1);
        cycle();
        check("s4_no_regrant", 32'(gnt_valid), 32'd0);
        req = 8'h00;
        cycle();

        // Scenario 5: asynchronous reset mid-grant
        do_reset();
        En  = 1'b1;
        req = 8'h20;
        cycle();
        check("s5_idx5", 32'(gnt_idx), 32'd5);
        req = 8'hFF;
        cycle();
        do_reset();
        check("s5_gnt0", 32'(gnt), 32'd0);
        cycle();
        check("s5_first0", 32'(gnt_idx), 32'd0);
        check("s5_valid", 32'(gnt_valid), 32'd1);

        // Scenario 6: release on the same edge as the hold limit
        do_reset();
        req = 8'h02;
        cycle();
        repeat (3) cycle();
        req = 8'h00;
        cycle();
        check("s6_release", 32'(gnt_valid), 32'd0);
        check("s6_no_to", 32'(timeout), 32'd0);

        // Random traffic
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                if ($urandom_range(0, 3) == 0) req = 8'($urandom);
                En = ($urandom_range(0, 3) != 0);
                cycle();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
